// File: rtl/adc_sequencer_pkg.sv
// rtl/adc_sequencer_pkg.sv - shared types and aux word layout for the ADC sequencer
package adc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CMD       = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    typedef enum logic {
        KIND_AUDIO = 1'b0,
        KIND_AUX   = 1'b1
    } kind_t;

    localparam int AUX_DATA_LSB = 0;
    localparam int AUX_DATA_MSB = 11;
    localparam int AUX_CHAN_LSB = 16;
    localparam int AUX_CHAN_MSB = 20;

    // Builds the CPU-facing housekeeping word; unused bits are zero.
    function automatic logic [31:0] pack_aux_word(input logic [4:0] chan, input logic [11:0] data);
        logic [31:0] word;
        word = '0;
        word[AUX_DATA_MSB:AUX_DATA_LSB] = data;
        word[AUX_CHAN_MSB:AUX_CHAN_LSB] = chan;
        return word;
    endfunction

endpackage

// File: rtl/adc_sequencer_if.sv
// rtl/adc_sequencer_if.sv - ADC IP command/response port bundle
interface adc_sequencer_if;
    logic       command_valid_out;
    logic [4:0] command_channel_out;
    logic       command_startofpacket_out;
    logic       command_endofpacket_out;
    logic       command_ready_in;
    logic       response_valid_in;
    logic [4:0] response_channel_in;
    logic [11:0] response_data_in;

    modport master (
        output command_valid_out,
        output command_channel_out,
        output command_startofpacket_out,
        output command_endofpacket_out,
        input  command_ready_in,
        input  response_valid_in,
        input  response_channel_in,
        input  response_data_in
    );

    modport slave (
        input  command_valid_out,
        input  command_channel_out,
        input  command_startofpacket_out,
        input  command_endofpacket_out,
        output command_ready_in,
        output response_valid_in,
        output response_channel_in,
        output response_data_in
    );
endinterface

// File: rtl/adc_aux_picker.sv
// rtl/adc_aux_picker.sv - round-robin next-set-bit search over the housekeeping mask
module adc_aux_picker (
    input  logic [15:0] mask,
    input  logic [3:0]  last_idx,
    output logic [3:0]  next_idx,
    output logic        found
);

    logic [3:0] idx;

    // Walk offsets from far to near so the nearest set bit after last_idx wins;
    // offset 16 wraps back onto last_idx itself when it is the only set bit.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int off = 16; off >= 1; off--) begin
            idx = last_idx + off[3:0];
            if (mask[idx]) begin
                found    = 1'b1;
                next_idx = idx;
            end
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - shares the ADC between audio sample ticks and CPU housekeeping polls
module adc_sequencer
    import adc_sequencer_pkg::*;
#(
    parameter int          AUDIO_CHANNEL = 1,
    parameter logic [15:0] AUX_MASK      = 16'h00F0,
    parameter int          TIMEOUT       = 64
) (
    input  logic               clk,
    input  logic               rst,
    adc_sequencer_if.master    adc,
    input  logic               audio_req_in,
    output logic [11:0]        audio_out,
    output logic               audio_stb_out,
    input  logic               aux_enable_in,
    output logic [31:0]        aux_out,
    output logic               aux_stb_out,
    input  logic               aux_ack_in,
    input  logic               clear_in,
    output logic               overrun_out,
    output logic               timeout_out,
    output logic               mismatch_out
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    kind_t       kind_q;
    logic [4:0]  chan_q;
    logic        audio_pend_q;
    logic [3:0]  last_aux_q;
    logic [7:0]  timer_q;
    logic [11:0] audio_q;
    logic        audio_stb_q;
    logic [31:0] aux_q;
    logic        aux_stb_q;
    logic        overrun_q, timeout_q, mismatch_q;
    logic        pkt_q;

    logic        take_audio, take_aux, resp_hit, resp_miss, timed_out;
    logic [3:0]  pick_idx;
    logic        pick_found;

    adc_aux_picker u_picker (
        .mask     (AUX_MASK),
        .last_idx (last_aux_q),
        .next_idx (pick_idx),
        .found    (pick_found)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Arbitration, command handshake and response classification.
    always_comb begin
        state_d    = state_q;
        take_audio = 1'b0;
        take_aux   = 1'b0;
        resp_hit   = 1'b0;
        resp_miss  = 1'b0;
        timed_out  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (audio_pend_q) begin
                    take_audio = 1'b1;
                    state_d    = ST_CMD;
                end else if (aux_enable_in && (AUX_MASK != 16'h0) && !aux_stb_q && pick_found) begin
                    take_aux = 1'b1;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                if (adc.command_ready_in) state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (adc.response_valid_in && adc.response_channel_in == chan_q) begin
                    resp_hit = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    resp_miss = adc.response_valid_in;
                    if (timer_q == TIMER_LAST) begin
                        timed_out = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issued-conversion bookkeeping: channel, kind, round-robin pointer and response timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q     <= KIND_AUDIO;
            chan_q     <= '0;
            last_aux_q <= 4'd15;
            timer_q    <= '0;
        end else begin
            if (take_audio) begin
                kind_q <= KIND_AUDIO;
                chan_q <= 5'(AUDIO_CHANNEL);
            end else if (take_aux) begin
                kind_q     <= KIND_AUX;
                chan_q     <= {1'b0, pick_idx};
                last_aux_q <= pick_idx;
            end
            if (state_q == ST_WAIT_RESP && state_d == ST_WAIT_RESP) timer_q <= timer_q + 8'd1;
            else                                                    timer_q <= '0;
        end
    end

    // Audio request latch; a request on top of an unserved one is lost and flagged.
    always_ff @(posedge clk) begin
        if (rst)               audio_pend_q <= 1'b0;
        else if (audio_req_in) audio_pend_q <= 1'b1;
        else if (take_audio)   audio_pend_q <= 1'b0;
    end

    // Result delivery: one-cycle audio strobe, held aux word until the CPU acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            audio_q     <= '0;
            audio_stb_q <= 1'b0;
            aux_q       <= '0;
            aux_stb_q   <= 1'b0;
        end else begin
            audio_stb_q <= resp_hit && (kind_q == KIND_AUDIO);
            if (resp_hit && kind_q == KIND_AUDIO) audio_q <= adc.response_data_in;
            if (resp_hit && kind_q == KIND_AUX) begin
                aux_q     <= pack_aux_word(chan_q, adc.response_data_in);
                aux_stb_q <= 1'b1;
            end else if (aux_stb_q && aux_ack_in) begin
                aux_stb_q <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            if (audio_req_in && audio_pend_q) overrun_q  <= 1'b1;
            else if (clear_in)                overrun_q  <= 1'b0;
            if (timed_out)                    timeout_q  <= 1'b1;
            else if (clear_in)                timeout_q  <= 1'b0;
            if (resp_miss)                    mismatch_q <= 1'b1;
            else if (clear_in)                mismatch_q <= 1'b0;
        end
    end

    // Every command is a single-beat packet; framing bits are low only while in reset.
    always_ff @(posedge clk) begin
        if (rst) pkt_q <= 1'b0;
        else     pkt_q <= 1'b1;
    end

    assign adc.command_valid_out         = (state_q == ST_CMD);
    assign adc.command_channel_out       = chan_q;
    assign adc.command_startofpacket_out = pkt_q;
    assign adc.command_endofpacket_out   = pkt_q;

    assign audio_out     = audio_q;
    assign audio_stb_out = audio_stb_q;
    assign aux_out       = aux_q;
    assign aux_stb_out   = aux_stb_q;
    assign overrun_out   = overrun_q;
    assign timeout_out   = timeout_q;
    assign mismatch_out  = mismatch_q;

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Schedules conversions on the MAX10 built-in ADC so that one resource serves two requesters. The audio path gets conversions on its sample tick, and spare housekeeping channels are polled round-robin for the CPU in idle slots. The block drives the ADC IP's Avalon-ST command port and routes responses to either a one-cycle audio strobe or a stb/ack word for the CPU. It sits between the ADC IP and the transceiver/CPU logic in the `clk_10` domain.

## Interface
- `AUDIO_CHANNEL`, default 1: ADC channel converted on each audio request.
- `AUX_MASK`, default 16'h00F0: bit i set means channel i is polled for the CPU. A mask of 0 disables polling.
- `TIMEOUT`, default 64: cycles allowed in WAIT_RESP, range 2..255.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high.
- `audio_req_in` in 1: single-cycle pulse requesting one audio conversion.
- `audio_out` out 12: last audio sample.
- `audio_stb_out` out 1: one-cycle strobe marking a new `audio_out`.
- `aux_enable_in` in 1: allows housekeeping polling.
- `aux_out` out 32: housekeeping word. [11:0] holds the data, [20:16] the channel, all other bits 0.
- `aux_stb_out` out 1: housekeeping word valid. Held until acknowledged.
- `aux_ack_in` in 1: CPU accepts the word.
- `command_valid_out` out 1, `command_channel_out` out 5, `command_startofpacket_out` out 1, `command_endofpacket_out` out 1: ADC command port.
- `command_ready_in` in 1: ADC command port ready.
- `response_valid_in` in 1, `response_channel_in` in 5, `response_data_in` in 12: ADC response port.
- `clear_in` in 1: clears all sticky flags.
- `overrun_out` out 1: sticky; an audio request was lost.
- `timeout_out` out 1: sticky; a conversion never answered.
- `mismatch_out` out 1: sticky; a response arrived with an unexpected channel.

## Operation
- **State machine.** States are IDLE, CMD and WAIT_RESP.
- **Audio pending.**
  - `audio_req_in` sets register `audio_pend`.
  - A request arriving while `audio_pend` is already 1 sets `overrun_out`. `audio_pend` stays 1.
- **IDLE arbitration.** Audio always has priority.
  - If `audio_pend` is set: load channel `AUDIO_CHANNEL`, mark the kind as audio, clear `audio_pend`, go to CMD.
  - Else if `aux_enable_in` is 1, `AUX_MASK` is non-zero and `aux_stb_out` is 0: load the next set mask bit strictly after `last_aux`, wrapping from 15 to 0. Mark the kind as aux, store `last_aux`, go to CMD.
  - `last_aux` resets to 15, so the first poll is the lowest set bit.
  - Otherwise stay in IDLE.
- **CMD.**
  - `command_valid_out` is 1. Start- and end-of-packet outputs are always 1.
  - The transfer happens when valid and `command_ready_in` are both 1; then go to WAIT_RESP.
  - CMD has no timeout.
- **WAIT_RESP.**
  - A response counts only if `response_valid_in` is 1 and `response_channel_in` equals the issued channel.
  - On a counted audio response: register the data into `audio_out` and pulse `audio_stb_out`.
  - On a counted aux response: load `aux_out` and set `aux_stb_out`.
  - After either, go to IDLE.
  - A valid response on another channel is dropped and sets `mismatch_out`. The block keeps waiting.
  - If the timer reaches `TIMEOUT` with no counted response: go to IDLE, set `timeout_out`, produce no output strobe.
- **Aux handshake.** `aux_stb_out` clears on the cycle after `aux_ack_in` is sampled high together with it. `aux_out` is stable while the strobe is set.
- **Responses outside WAIT_RESP** are dropped silently.
- **Sticky flags.** `clear_in` clears all three. If `clear_in` and a new set condition occur in the same cycle, the set wins.

## Timing
- **Reset values.**
  - State IDLE, `audio_pend` 0, `last_aux` 15, timer 0.
  - All outputs 0, including `audio_out`, `aux_out` and the sticky flags.
  - Start- and end-of-packet outputs are 0 during reset and 1 from then on.
- **Reset mid-operation** abandons any in-flight command. A late response after reset arrives in IDLE and is dropped.
- **Request to command.** `audio_req_in` at cycle n sets `audio_pend` at n+1. IDLE arbitration at n+1 puts `command_valid_out` high at n+2.
- **Response to output.** A response at cycle m gives `audio_stb_out` or `aux_stb_out` high at m+1. The state is IDLE at m+1, so the next command's valid is high at m+2 at the earliest.
- **Timer.** Cleared on entry to WAIT_RESP and incremented each cycle spent there. The timeout exit happens on the cycle the count equals `TIMEOUT`-1.
- **Audio request while busy.** A request during CMD or WAIT_RESP of an audio conversion sets pending normally and is served on the next IDLE.

## Structure
- Package `adc_sequencer_pkg` holds:
  - the state encoding;
  - the kind encoding (audio/aux);
  - the aux word field positions (data 11:0, channel 20:16).
- One sub-module, `adc_aux_picker`: combinational round-robin next-set-bit over a 16-bit mask and a 4-bit last index.

## Test plan
- **Reset.** Assert `rst` for 3 cycles with `audio_req_in` high. All outputs must be 0 and the state IDLE; `command_valid_out` stays 0 the cycle after release.
- **Audio conversion.**
  - Stimulus: `audio_req_in` pulse; ready tied 1; response after 5 cycles with channel 1, data 12'hABC.
  - Required: command channel 1 issued 2 cycles after the request; `audio_out` = 12'hABC with a one-cycle strobe.
- **Round-robin.**
  - Stimulus: `aux_enable_in` 1, `AUX_MASK` 16'h00F0, CPU acks each word immediately.
  - Required: channels polled in order 4, 5, 6, 7, 4; each `aux_out` = {11'b0, ch, 4'b0, data}.
- **Audio priority and overrun.**
  - Stimulus: aux word left unacknowledged; two audio pulses while an aux conversion is in flight; a third pulse before the pending request is issued.
  - Required: no further aux poll until ack; audio issued next; `overrun_out` = 1.
- **Timeout and mismatch.**
  - Stimulus: `TIMEOUT` 8; issue an audio conversion; inject a response on channel 3; then no response.
  - Required: `mismatch_out` = 1; return to IDLE after 8 WAIT_RESP cycles; `timeout_out` = 1; no `audio_stb_out`.
  - Then pulse `clear_in` with no new events: both flags return to 0.
- **Held-off ready.** Hold `command_ready_in` low for 200 cycles. `command_valid_out` stays 1, channel is stable, and `timeout_out` stays 0.
